game_sequencer: RTL and testbench

- Top-level mode controller for the binary refinement game.
- Sequences five modes: name entry, your-score, leaderboard, timed challenge, result.
- Generates the random 8-bit challenge, runs the countdown, scores submissions and maintains the leaderboard.
- Consumes debounced single-cycle button pulses and the 1 Hz tick; drives mode and data to the display demux.

---
 rtl/game_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: top-level mode controller for the binary refinement game.
// Walks the player through name entry, score/leaderboard display, a timed
// challenge round and a result screen. Generates the 8-bit challenge from a
// free-running LFSR, counts the round down on the 1 Hz tick, scores the
// submission and keeps the single-entry leaderboard. Every output is a register.
module game_sequencer #(
  parameter int unsigned GAME_TIME   = 20,     // challenge length in seconds (1..63)
  parameter int unsigned RESULT_TIME = 2,      // seconds the result is shown (1..15)
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,  // LFSR reset value, must be nonzero
  parameter int unsigned SCORE_W     = 16      // width of score registers
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic               btn_newgame,
  input  logic               btn_newplayer,
  input  logic               btn_score,
  input  logic               btn_submit,
  input  logic [7:0]         sw,
  input  logic               key_valid,
  input  logic [3:0]         key_digit,
  output logic [2:0]         mode,
  output logic [7:0]         challenge,
  output logic [5:0]         time_left,
  output logic               is_correct,
  output logic [SCORE_W-1:0] round_points,
  output logic [SCORE_W-1:0] your_score,
  output logic [11:0]        your_name,
  output logic [11:0]        name_entry,
  output logic [1:0]         digits_entered,
  output logic [SCORE_W-1:0] leader_score,
  output logic [11:0]        leader_name
);

  // Encodings match the display demux's mode decoding.
  typedef enum logic [2:0] {
    M_SCORE     = 3'b000,
    M_LEADER    = 3'b001,
    M_GAME      = 3'b010,
    M_RESULT    = 3'b011,
    M_NEWPLAYER = 3'b100
  } mode_t;

  localparam logic [5:0] GAME_TIME_V   = 6'(GAME_TIME);
  localparam logic [3:0] RESULT_TIME_V = 4'(RESULT_TIME);

  mode_t              state;
  logic [7:0]         lfsr;
  logic               lfsr_fb;
  logic [3:0]         res_cnt;

  logic               guess_ok;
  logic [SCORE_W-1:0] earned;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] next_score;
  logic               digit_ok;

  // Taps for x^8+x^6+x^5+x^4+1; a nonzero seed keeps the register off the
  // all-zero lock-up state forever.
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  assign mode = state;

  // Submission scoring: points equal the seconds still on the clock, and the
  // running total saturates instead of wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned, which is what would otherwise infer a latch.
    guess_ok   = 1'b0;
    earned     = '0;
    score_sum  = '0;
    next_score = '0;
    digit_ok   = 1'b0;

    guess_ok   = (sw == challenge);
    earned     = guess_ok ? SCORE_W'(time_left) : '0;
    score_sum  = {1'b0, your_score} + {1'b0, earned};
    next_score = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    digit_ok   = key_valid && (key_digit <= 4'd9) && (digits_entered != 2'd3);
  end

  // Free-running challenge source, stepping every clock outside reset.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register in
    // the design samples the pre-edge values, regardless of statement order.
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end

  // Mode FSM together with every registered output it owns.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= M_NEWPLAYER;
      challenge      <= '0;
      time_left      <= '0;
      is_correct     <= 1'b0;
      round_points   <= '0;
      your_score     <= '0;
      your_name      <= '0;
      name_entry     <= '0;
      digits_entered <= '0;
      leader_score   <= '0;
      leader_name    <= '0;
      res_cnt        <= '0;
    end else begin
      case (state)
        // Collect three decimal digits, then hand the name to the score view.
        M_NEWPLAYER: begin
          if (btn_submit && (digits_entered == 2'd3)) begin
            your_name  <= name_entry;
            your_score <= '0;
            state      <= M_SCORE;
          end else if (digit_ok) begin
            // First digit typed ends up in [11:8] after three shifts.
            name_entry     <= {name_entry[7:0], key_digit};
            digits_entered <= digits_entered + 2'd1;
          end
        end

        // Idle views: newplayer beats newgame beats the view toggle.
        M_SCORE, M_LEADER: begin
          if (btn_newplayer) begin
            name_entry     <= '0;
            digits_entered <= '0;
            state          <= M_NEWPLAYER;
          end else if (btn_newgame) begin
            challenge <= lfsr;
            time_left <= GAME_TIME_V;
            state     <= M_GAME;
          end else if (btn_score) begin
            state <= (state == M_SCORE) ? M_LEADER : M_SCORE;
          end
        end

        // Countdown. A submit in the same cycle as a tick is scored with the
        // pre-decrement time and suppresses the timeout.
        M_GAME: begin
          if (btn_submit) begin
            is_correct   <= guess_ok;
            round_points <= earned;
            your_score   <= next_score;
            // Strict compare: an equal score does not displace the holder.
            if (next_score > leader_score) begin
              leader_score <= next_score;
              leader_name  <= your_name;
            end
            res_cnt <= '0;
            state   <= M_RESULT;
          end else if (tick_1hz) begin
            if (time_left == 6'd1) begin
              time_left    <= '0;
              is_correct   <= 1'b0;
              round_points <= '0;
              res_cnt      <= '0;
              state        <= M_RESULT;
            end else begin
              time_left <= time_left - 6'd1;
            end
          end
        end

        // Show the outcome for RESULT_TIME seconds; buttons are ignored here.
        M_RESULT: begin
          if (tick_1hz) begin
            res_cnt <= res_cnt + 4'd1;
            if ((res_cnt + 4'd1) == RESULT_TIME_V) begin
              state <= M_SCORE;
            end
          end
        end

        default: begin
          state <= M_NEWPLAYER;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Testbench for game_sequencer: directed scenarios followed by randomized
// button/tick traffic. A reference model written in terms of the game rules
// predicts every output after each clock; a separate monitor compares.
module tb_game_sequencer;

  localparam int          GT   = 20;
  localparam int          RT   = 2;
  localparam int          SW   = 8;   // narrow scores so saturation is reachable
  localparam logic [7:0]  SEED = 8'hA5;
  localparam int          SMAX = (1 << SW) - 1;

  localparam int MD_SCORE  = 0;
  localparam int MD_LEADER = 1;
  localparam int MD_GAME   = 2;
  localparam int MD_RESULT = 3;
  localparam int MD_NP     = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick_1hz, btn_newgame, btn_newplayer, btn_score, btn_submit;
  logic [7:0]    sw;
  logic          key_valid;
  logic [3:0]    key_digit;
  logic [2:0]    mode;
  logic [7:0]    challenge;
  logic [5:0]    time_left;
  logic          is_correct;
  logic [SW-1:0] round_points, your_score, leader_score;
  logic [11:0]   your_name, name_entry, leader_name;
  logic [1:0]    digits_entered;

  game_sequencer #(
    .GAME_TIME(GT), .RESULT_TIME(RT), .LFSR_SEED(SEED), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_newgame(btn_newgame), .btn_newplayer(btn_newplayer),
    .btn_score(btn_score), .btn_submit(btn_submit),
    .sw(sw), .key_valid(key_valid), .key_digit(key_digit),
    .mode(mode), .challenge(challenge), .time_left(time_left),
    .is_correct(is_correct), .round_points(round_points),
    .your_score(your_score), .your_name(your_name),
    .name_entry(name_entry), .digits_entered(digits_entered),
    .leader_score(leader_score), .leader_name(leader_name)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    mode;
    logic [7:0]    challenge;
    logic [5:0]    time_left;
    logic          is_correct;
    logic [SW-1:0] round_points;
    logic [SW-1:0] your_score;
    logic [11:0]   your_name;
    logic [11:0]   name_entry;
    logic [1:0]    digits_entered;
    logic [SW-1:0] leader_score;
    logic [11:0]   leader_name;
  } snap_t;

  snap_t exp_q[$];
  snap_t got_e;
  int    vectors     = 0;
  int    miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (game rules) ----------------
  int         m_mode, m_name, m_score, m_lead, m_lead_name;
  int         m_chal, m_time, m_corr, m_pts, m_rticks;
  int         digits[$];
  logic [7:0] m_lfsr = 8'h00;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic int entry_val();
    int v = 0;
    foreach (digits[i]) v = v * 16 + digits[i];
    return v;
  endfunction

  task automatic model_reset();
    m_mode = MD_NP; m_name = 0; m_score = 0; m_lead = 0; m_lead_name = 0;
    m_chal = 0; m_time = 0; m_corr = 0; m_pts = 0; m_rticks = 0;
    digits.delete();
  endtask

  task automatic model_step();
    logic [7:0] cur;
    snap_t      s;
    cur    = m_lfsr;
    m_lfsr = rst ? SEED : lfsr_next(m_lfsr);
    if (rst) begin
      model_reset();
    end else begin
      case (m_mode)
        MD_NP: begin
          if (btn_submit && digits.size() == 3) begin
            m_name = entry_val(); m_score = 0; m_mode = MD_SCORE;
          end else if (key_valid && key_digit <= 9 && digits.size() < 3) begin
            digits.push_back(int'(key_digit));
          end
        end
        MD_SCORE, MD_LEADER: begin
          if (btn_newplayer) begin
            digits.delete(); m_mode = MD_NP;
          end else if (btn_newgame) begin
            m_chal = int'(cur); m_time = GT; m_mode = MD_GAME;
          end else if (btn_score) begin
            m_mode = (m_mode == MD_SCORE) ? MD_LEADER : MD_SCORE;
          end
        end
        MD_GAME: begin
          if (btn_submit) begin
            m_corr  = (int'(sw) == m_chal) ? 1 : 0;
            m_pts   = m_corr ? m_time : 0;
            m_score = (m_score + m_pts > SMAX) ? SMAX : m_score + m_pts;
            if (m_score > m_lead) begin
              m_lead = m_score; m_lead_name = m_name;
            end
            m_rticks = 0; m_mode = MD_RESULT;
          end else if (tick_1hz) begin
            m_time--;
            if (m_time == 0) begin
              m_corr = 0; m_pts = 0; m_rticks = 0; m_mode = MD_RESULT;
            end
          end
        end
        MD_RESULT: begin
          if (tick_1hz) begin
            m_rticks++;
            if (m_rticks == RT) m_mode = MD_SCORE;
          end
        end
        default: ;
      endcase
    end
    s.mode           = 3'(m_mode);
    s.challenge      = 8'(m_chal);
    s.time_left      = 6'(m_time);
    s.is_correct     = 1'(m_corr);
    s.round_points   = SW'(m_pts);
    s.your_score     = SW'(m_score);
    s.your_name      = 12'(m_name);
    s.name_entry     = 12'(entry_val());
    s.digits_entered = 2'(digits.size());
    s.leader_score   = SW'(m_lead);
    s.leader_name    = 12'(m_lead_name);
    exp_q.push_back(s);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        got_e = exp_q.pop_front();
        check("mode",           32'(mode),           32'(got_e.mode));
        check("challenge",      32'(challenge),      32'(got_e.challenge));
        check("time_left",      32'(time_left),      32'(got_e.time_left));
        check("is_correct",     32'(is_correct),     32'(got_e.is_correct));
        check("round_points",   32'(round_points),   32'(got_e.round_points));
        check("your_score",     32'(your_score),     32'(got_e.your_score));
        check("your_name",      32'(your_name),      32'(got_e.your_name));
        check("name_entry",     32'(name_entry),     32'(got_e.name_entry));
        check("digits_entered", 32'(digits_entered), 32'(got_e.digits_entered));
        check("leader_score",   32'(leader_score),   32'(got_e.leader_score));
        check("leader_name",    32'(leader_name),    32'(got_e.leader_name));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_pulses();
    tick_1hz = 0; btn_newgame = 0; btn_newplayer = 0; btn_score = 0;
    btn_submit = 0; key_valid = 0; key_digit = 0;
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    clear_pulses();
  endtask

  task automatic key(input int d);
    key_valid = 1; key_digit = 4'(d); step();
  endtask

  task automatic submit();
    btn_submit = 1; step();
  endtask

  task automatic newgame();
    btn_newgame = 1; step();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_1hz = 1; step(); step();
    end
  endtask

  task automatic enter_name(input int a, input int b, input int c);
    key(a); key(b); key(c); submit();
  endtask

  task automatic play(input int nt, input bit right);
    newgame();
    ticks(nt);
    sw = right ? 8'(m_chal) : 8'(m_chal) ^ 8'h01;
    submit();
    ticks(RT);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1; sw = 0;
    clear_pulses();
    model_reset();
    @(negedge clk);
    step(); step();
    rst = 0;
    step(); step();
    check("reset_mode", 32'(mode), 32'd4);

    // Name entry: short submit ignored, invalid digit and 4th digit ignored.
    key(4); key(2); submit();
    check("short_submit_mode", 32'(mode), 32'd4);
    key(12); key(7); key(8);
    check("name_entry_427", 32'(name_entry), 32'h427);
    submit();
    check("your_name_427", 32'(your_name), 32'h427);
    check("mode_score", 32'(mode), 32'd0);

    // Wait for the LFSR to reach 8'h3C, then play a correct round at 15 s.
    for (int i = 0; i < 300 && m_lfsr != 8'h3C; i++) step();
    newgame();
    check("challenge_3c", 32'(challenge), 32'h3C);
    check("time_left_20", 32'(time_left), 32'd20);
    ticks(5);
    sw = 8'h3C;
    submit();
    check("correct_flag", 32'(is_correct), 32'd1);
    check("points_15", 32'(round_points), 32'd15);
    check("score_15", 32'(your_score), 32'd15);
    check("leader_15", 32'(leader_score), 32'd15);
    check("mode_result", 32'(mode), 32'd3);
    ticks(RT);
    check("result_to_score", 32'(mode), 32'd0);

    // Wrong answer leaves the score alone.
    play(3, 1'b0);
    check("wrong_score_kept", 32'(your_score), 32'd15);

    // Second player ties the leader: holder unchanged.
    btn_newplayer = 1; step();
    enter_name(1, 2, 3);
    play(5, 1'b1);
    check("tie_score", 32'(your_score), 32'd15);
    check("tie_leader_name", 32'(leader_name), 32'h427);

    // Timeout round.
    newgame();
    ticks(GT);
    check("timeout_mode", 32'(mode), 32'd3);
    check("timeout_time", 32'(time_left), 32'd0);
    check("timeout_correct", 32'(is_correct), 32'd0);
    ticks(RT);

    // Submit coincident with the last tick: scored with 1 point, no timeout.
    newgame();
    ticks(GT - 1);
    check("time_left_1", 32'(time_left), 32'd1);
    sw = 8'(m_chal); tick_1hz = 1; btn_submit = 1; step();
    check("last_second_points", 32'(round_points), 32'd1);
    check("last_second_correct", 32'(is_correct), 32'd1);
    ticks(RT);

    // newplayer wins over newgame.
    btn_newplayer = 1; btn_newgame = 1; step();
    check("priority_np", 32'(mode), 32'd4);
    enter_name(9, 0, 5);

    // Saturation: instant correct submits worth 20 points each.
    repeat (14) begin
      newgame();
      sw = 8'(m_chal);
      submit();
      ticks(RT);
    end
    check("saturated", 32'(your_score), 32'(SMAX));
    check("sat_leader_name", 32'(leader_name), 32'h905);

    // Reset in the middle of a game.
    newgame();
    ticks(13);
    check("time_left_7", 32'(time_left), 32'd7);
    rst = 1; step(); rst = 0;
    check("rst_mode", 32'(mode), 32'd4);
    check("rst_score", 32'(your_score), 32'd0);
    check("rst_leader", 32'(leader_score), 32'd0);
    check("rst_challenge", 32'(challenge), 32'd0);

    // Randomized traffic against the model.
    repeat (2500) begin
      tick_1hz      = ($urandom_range(0, 3) == 0);
      btn_newgame   = ($urandom_range(0, 15) == 0);
      btn_newplayer = ($urandom_range(0, 23) == 0);
      btn_score     = ($urandom_range(0, 7) == 0);
      btn_submit    = ($urandom_range(0, 7) == 0);
      key_valid     = ($urandom_range(0, 2) == 0);
      key_digit     = 4'($urandom_range(0, 15));
      sw            = ($urandom_range(0, 1) == 1) ? 8'(m_chal) : 8'($urandom);
      rst           = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0;

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
